// File: rtl/master_port.sv
// Bus master port: takes one parallel request, arbitrates for the bus and
// serialises the address (and write data) LSB first, or collects serial read data.
module master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              in_clk,
  input  logic              reset,
  input  logic              par_req_valid,
  input  logic              par_write,
  input  logic [ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0] par_wdata,
  output logic              par_ready,
  output logic [DATA_W-1:0] par_rdata,
  output logic              par_rdata_valid,
  output logic              par_done,
  output logic              par_error,
  output logic              out_bus_req,
  input  logic              in_bus_grant,
  output logic              out_write,
  output logic              ser_addr,
  output logic              ser_wdata,
  output logic              ser_out_valid,
  input  logic              ser_rdata,
  input  logic              ser_in_valid
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, TX_ADDR, TX_DATA, RX_DATA, DONE
  } state_t;

  state_t              state_q;
  logic                write_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;

  // Handshake: a request is taken on any rising edge where par_ready (IDLE) and
  // par_req_valid are both 1; its fields are copied then and never re-sampled.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (par_req_valid) begin
            write_q    <= par_write;
            addr_q     <= par_addr;
            wdata_q    <= par_wdata;
            rx_q       <= '0;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (in_bus_grant) state_q <= TX_ADDR;
        end
        TX_ADDR: begin
          if (!in_bus_grant) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q <= addr_q >> 1;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= write_q ? TX_DATA : RX_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (!in_bus_grant) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wdata_q <= wdata_q >> 1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        RX_DATA: begin
          // Grant loss wins over a final bit or timeout in the same cycle.
          if (!in_bus_grant) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (ser_in_valid) begin
            wait_cnt_q <= '0;
            rx_q       <= {ser_rdata, rx_q[DATA_W-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              rdata_q   <= {ser_rdata, rx_q[DATA_W-1:1]};
              bit_cnt_q <= '0;
              state_q   <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign par_ready       = (state_q == IDLE);
  assign out_bus_req     = (state_q == REQ) || (state_q == TX_ADDR) ||
                           (state_q == TX_DATA) || (state_q == RX_DATA);
  assign ser_out_valid   = (state_q == TX_ADDR) || (state_q == TX_DATA);
  assign ser_addr        = (state_q == TX_ADDR) && addr_q[0];
  assign ser_wdata       = (state_q == TX_DATA) && wdata_q[0];
  assign out_write       = (state_q != IDLE) && write_q;
  assign par_done        = (state_q == DONE);
  assign par_error       = (state_q == DONE) && err_q;
  assign par_rdata_valid = (state_q == DONE) && !err_q && !write_q;
  assign par_rdata       = rdata_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: serial bits and completions are checked
// against expectations queued when each request is issued.
module tb_master_port;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;

  logic              in_clk;
  logic              reset;
  logic              par_req_valid;
  logic              par_write;
  logic [ADDR_W-1:0] par_addr;
  logic [DATA_W-1:0] par_wdata;
  logic              par_ready;
  logic [DATA_W-1:0] par_rdata;
  logic              par_rdata_valid;
  logic              par_done;
  logic              par_error;
  logic              out_bus_req;
  logic              in_bus_grant;
  logic              out_write;
  logic              ser_addr;
  logic              ser_wdata;
  logic              ser_out_valid;
  logic              ser_rdata;
  logic              ser_in_valid;

  master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .in_clk          (in_clk),
    .reset           (reset),
    .par_req_valid   (par_req_valid),
    .par_write       (par_write),
    .par_addr        (par_addr),
    .par_wdata       (par_wdata),
    .par_ready       (par_ready),
    .par_rdata       (par_rdata),
    .par_rdata_valid (par_rdata_valid),
    .par_done        (par_done),
    .par_error       (par_error),
    .out_bus_req     (out_bus_req),
    .in_bus_grant    (in_bus_grant),
    .out_write       (out_write),
    .ser_addr        (ser_addr),
    .ser_wdata       (ser_wdata),
    .ser_out_valid   (ser_out_valid),
    .ser_rdata       (ser_rdata),
    .ser_in_valid    (ser_in_valid)
  );

  // clock / reset
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // scoreboard state: {addr_bit, wdata_bit} per serial cycle, {err, rdv, rdata} per completion
  logic [1:0]        exp_bit_q[$];
  logic [DATA_W+1:0] exp_res_q[$];
  logic [DATA_W-1:0] last_rdata;
  logic              exp_dir;
  logic [1:0]        mon_bit;
  logic [DATA_W+1:0] mon_res;
  int                n_cmp;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge in_clk) begin
    if (!reset) begin
      if (ser_out_valid) begin
        if (exp_bit_q.size() == 0) check("ser_unexpected", 32'd1, 32'd0);
        else begin
          mon_bit = exp_bit_q.pop_front();
          check("ser_bits", {30'd0, ser_addr, ser_wdata}, {30'd0, mon_bit});
        end
      end else begin
        check("ser_idle_zero", {30'd0, ser_addr, ser_wdata}, 32'd0);
      end
      if (par_done) begin
        if (exp_res_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          mon_res = exp_res_q.pop_front();
          check("done_result", {22'd0, par_error, par_rdata_valid, par_rdata}, {22'd0, mon_res});
        end
      end else begin
        check("rdv_outside_done", {31'd0, par_rdata_valid}, 32'd0);
      end
      check("out_write", {31'd0, out_write}, {31'd0, (par_ready ? 1'b0 : exp_dir)});
      check("bus_req", {31'd0, out_bus_req}, {31'd0, (!par_ready && !par_done)});
    end
  end

  // driver tasks
  task automatic accept(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] rd, input logic exp_err);
    check("ready_before_accept", {31'd0, par_ready}, 32'd1);
    par_req_valid = 1'b1;
    par_write     = w;
    par_addr      = a;
    par_wdata     = d;
    exp_dir       = w;
    for (int k = 0; k < ADDR_W; k++) exp_bit_q.push_back({a[k], 1'b0});
    if (w) for (int k = 0; k < DATA_W; k++) exp_bit_q.push_back({1'b0, d[k]});
    if (exp_err) exp_res_q.push_back({2'b10, last_rdata});
    else if (w) exp_res_q.push_back({2'b00, last_rdata});
    else begin
      exp_res_q.push_back({2'b01, rd});
      last_rdata = rd;
    end
    @(negedge in_clk);
    par_req_valid = 1'b0;
    par_write     = ~w;
    par_addr      = ADDR_W'($urandom);
    par_wdata     = DATA_W'($urandom);
    check("accepted_not_ready", {31'd0, par_ready}, 32'd0);
  endtask

  task automatic wait_done(input int limit, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      @(negedge in_clk);
      n++;
      if (par_done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ser_end();
    int g;
    g = 0;
    while (!ser_out_valid && g < 100) begin @(negedge in_clk); g++; end
    while (ser_out_valid && g < 200) begin @(negedge in_clk); g++; end
    if (g >= 200) check("ser_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_valid(input int target);
    int c;
    int g;
    c = 0;
    g = 0;
    while (c < target && g < 200) begin
      @(negedge in_clk);
      g++;
      if (ser_out_valid) c++;
    end
    if (c < target) check("valid_count_timeout", 32'(c), 32'(target));
  endtask

  task automatic drive_read(input logic [DATA_W-1:0] v);
    wait_ser_end();
    for (int k = 0; k < DATA_W; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge in_clk);
      ser_in_valid = 1'b1;
      ser_rdata    = v[k];
      @(negedge in_clk);
      ser_in_valid = 1'b0;
      ser_rdata    = 1'b0;
    end
  endtask

  // directed sequence
  initial begin
    int n;
    n_cmp = 0; n_fail = 0;
    last_rdata = '0; exp_dir = 1'b0;
    reset = 1'b1; par_req_valid = 1'b0; par_write = 1'b0; par_addr = '0; par_wdata = '0;
    in_bus_grant = 1'b0; ser_rdata = 1'b0; ser_in_valid = 1'b0;
    repeat (3) @(negedge in_clk);
    check("reset_ready", {31'd0, par_ready}, 32'd1);
    check("reset_outputs", {out_bus_req, out_write, ser_addr, ser_wdata, ser_out_valid,
                            par_done, par_error, par_rdata_valid, par_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge in_clk);

    // write with grant held: done at G+21
    in_bus_grant = 1'b1;
    accept(1'b1, 12'hA5C, 8'h3B, 8'h00, 1'b0);
    wait_done(400, n);
    check("write_latency", 32'(n), 32'd21);
    @(negedge in_clk);
    check("write_bits_drained", 32'(exp_bit_q.size()), 32'd0);

    // read with gapped serial data
    accept(1'b0, 12'h123, 8'h00, 8'hC6, 1'b0);
    fork
      drive_read(8'hC6);
      wait_done(400, n);
    join
    @(negedge in_clk);
    check("read_rdata_hold", {24'd0, par_rdata}, 32'h0000_00C6);

    // read timeout: no valid bits
    accept(1'b0, 12'h0F0, 8'h00, 8'h00, 1'b1);
    wait_ser_end();
    wait_done(400, n);
    check("timeout_latency", 32'(n), 32'(TIMEOUT));
    @(negedge in_clk);
    check("timeout_rdata_kept", {24'd0, par_rdata}, 32'h0000_00C6);

    // grant dropped during the 5th address bit
    accept(1'b1, 12'h3C7, 8'h5A, 8'h00, 1'b1);
    count_valid(5);
    in_bus_grant = 1'b0;
    @(negedge in_clk);
    check("drop_done", {30'd0, par_done, par_error}, 32'd3);
    check("drop_bits_left", 32'(exp_bit_q.size()), 32'(ADDR_W + DATA_W - 5));
    exp_bit_q.delete();
    repeat (3) begin
      @(negedge in_clk);
      check("drop_quiet", {30'd0, ser_out_valid, par_ready}, 32'd1);
    end

    // grant withheld 10 cycles, request inputs toggling
    accept(1'b1, 12'h6E1, 8'h94, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("withheld_state", {29'd0, out_bus_req, ser_out_valid, par_ready}, 32'd4);
      par_req_valid = 1'($urandom_range(0, 1));
      par_addr      = ADDR_W'($urandom);
      par_wdata     = DATA_W'($urandom);
      @(negedge in_clk);
    end
    par_req_valid = 1'b0;
    in_bus_grant  = 1'b1;
    wait_done(400, n);
    check("withheld_latency", 32'(n), 32'd21);
    @(negedge in_clk);
    check("withheld_bits_drained", 32'(exp_bit_q.size()), 32'd0);

    // reset during TX_DATA, then an immediate write
    accept(1'b1, 12'h9B2, 8'hE7, 8'h00, 1'b0);
    count_valid(ADDR_W + 3);
    reset = 1'b1;
    #1;
    check("midreset_ready", {31'd0, par_ready}, 32'd1);
    check("midreset_outputs", {out_bus_req, out_write, ser_addr, ser_wdata, ser_out_valid,
                               par_done, par_error, par_rdata_valid, par_rdata}, 32'd0);
    exp_bit_q.delete();
    exp_res_q.delete();
    last_rdata = '0;
    repeat (3) begin
      @(negedge in_clk);
      check("midreset_no_done", {31'd0, par_done}, 32'd0);
    end
    reset = 1'b0;
    accept(1'b1, 12'h5E3, 8'h81, 8'h00, 1'b0);
    wait_done(400, n);
    check("post_reset_latency", 32'(n), 32'd21);
    @(negedge in_clk);

    // final report
    check("bits_queue_empty", 32'(exp_bit_q.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
